// File: rtl/nes_pkg.sv
// Shared definitions for the NES pad reader: button bit positions and reader states.
package nes_pkg;

  localparam int BTN_A     = 0;
  localparam int BTN_B     = 1;
  localparam int BTN_SEL   = 2;
  localparam int BTN_START = 3;
  localparam int BTN_UP    = 4;
  localparam int BTN_DOWN  = 5;
  localparam int BTN_LEFT  = 6;
  localparam int BTN_RIGHT = 7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } nes_state_t;

  // Length of one complete pad read in clock cycles.
  function automatic int transaction_cycles(input int half_cycles);
    return 17 * half_cycles + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/nes_pad_reader.sv
// Periodically reads an NES (CD4021) pad and publishes held and newly pressed button masks.
module nes_pad_reader
  import nes_pkg::*;
#(
  parameter int POLL_CYCLES = 1_083_333,
  parameter int HALF_CYCLES = 390
) (
  input  logic       vclk_in,
  input  logic       rst_in,
  input  logic       nes_data_in,
  output logic       nes_latch_out,
  output logic       nes_clk_out,
  output logic [7:0] buttons_out,
  output logic [7:0] pressed_out,
  output logic       valid_out
);

  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int HW = (2 * HALF_CYCLES > 1) ? $clog2(2 * HALF_CYCLES) : 1;
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);
  localparam logic [HW-1:0] LATCH_LAST = HW'(2 * HALF_CYCLES - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_CYCLES - 1);

  nes_state_t   r_state;
  logic [PW-1:0] r_poll;
  logic [HW-1:0] r_half;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_latch;
  logic          r_clk;
  logic [7:0]    r_buttons;
  logic [7:0]    r_pressed;
  logic          r_valid;

  logic       w_data_sync;
  logic       w_tick;
  logic [7:0] w_sample;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_data_sync (
    .i_clk(vclk_in),
    .i_rst(rst_in),
    .i_d  (nes_data_in),
    .o_q  (w_data_sync)
  );

  assign w_tick = (r_poll == POLL_LAST);

  // Shift register with the bit currently being read merged in; pad data is active-low.
  always_comb begin
    w_sample        = r_shift;
    w_sample[r_idx] = ~w_data_sync;
  end

  always_ff @(posedge vclk_in) begin
    if (rst_in) begin
      r_state   <= IDLE;
      r_poll    <= '0;
      r_half    <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_latch   <= 1'b0;
      r_clk     <= 1'b0;
      r_buttons <= '0;
      r_pressed <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_poll <= w_tick ? '0 : r_poll + PW'(1);

      case (r_state)
        IDLE: begin
          r_latch   <= 1'b0;
          r_clk     <= 1'b0;
          r_valid   <= 1'b0;
          r_pressed <= '0;
          if (w_tick) begin
            r_state <= LATCH;
            r_latch <= 1'b1;
            r_half  <= '0;
            r_idx   <= '0;
            r_shift <= '0;
          end
        end

        LATCH: begin
          if (r_half == LATCH_LAST) begin
            r_state <= LOW;
            r_latch <= 1'b0;
            r_half  <= '0;
          end else begin
            r_half <= r_half + HW'(1);
          end
        end

        // Sample at the end of the low phase so the pad output has settled longest.
        LOW: begin
          if (r_half == HALF_LAST) begin
            r_shift <= w_sample;
            r_half  <= '0;
            if (r_idx == 3'd7) begin
              r_state   <= DONE;
              r_buttons <= w_sample;
              r_pressed <= w_sample & ~r_buttons;
              r_valid   <= 1'b1;
            end else begin
              r_state <= HIGH;
              r_clk   <= 1'b1;
            end
          end else begin
            r_half <= r_half + HW'(1);
          end
        end

        HIGH: begin
          if (r_half == HALF_LAST) begin
            r_state <= LOW;
            r_clk   <= 1'b0;
            r_idx   <= r_idx + 3'd1;
            r_half  <= '0;
          end else begin
            r_half <= r_half + HW'(1);
          end
        end

        DONE: begin
          r_state   <= IDLE;
          r_valid   <= 1'b0;
          r_pressed <= '0;
        end

        default: begin
          r_state <= IDLE;
          r_latch <= 1'b0;
          r_clk   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // A poll period shorter than one read would silently drop every other transaction.
  always_ff @(posedge vclk_in) begin
    assert (POLL_CYCLES > transaction_cycles(HALF_CYCLES));
  end

  assign nes_latch_out = r_latch;
  assign nes_clk_out   = r_clk;
  assign buttons_out   = r_buttons;
  assign pressed_out   = r_pressed;
  assign valid_out     = r_valid;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader: behavioural 4021 pad, table vectors, random polls, timing and reset corners.
module tb_nes_pad_reader;
  import nes_pkg::*;

  localparam int POLL = 100;
  localparam int HALF = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       nes_data;
  logic       nes_latch;
  logic       nes_clk;
  logic [7:0] buttons;
  logic [7:0] pressed;
  logic       valid;

  always #5 clk = ~clk;

  nes_pad_reader #(
    .POLL_CYCLES(POLL),
    .HALF_CYCLES(HALF)
  ) dut (
    .vclk_in      (clk),
    .rst_in       (rst),
    .nes_data_in  (nes_data),
    .nes_latch_out(nes_latch),
    .nes_clk_out  (nes_clk),
    .buttons_out  (buttons),
    .pressed_out  (pressed),
    .valid_out    (valid)
  );

  // Behavioural CD4021: parallel load while latch is high, shift toward Q8 on clock rise.
  logic [7:0] pad_buttons = 8'h00;
  logic       unplugged   = 1'b0;
  logic [7:0] pad_sr      = 8'hFF;

  always @(posedge nes_clk or posedge nes_latch) begin
    if (nes_latch) pad_sr <= ~pad_buttons;
    else           pad_sr <= {1'b1, pad_sr[7:1]};
  end

  assign nes_data = unplugged ? 1'b1 : pad_sr[0];

  typedef struct {
    logic [7:0] pad;
    logic       unpl;
    logic [7:0] exp_buttons;
    logic [7:0] exp_pressed;
  } vec_t;

  vec_t vecs[6];

  int checks     = 0;
  int failures   = 0;
  int ncount     = 0;
  int last_valid = 0;
  logic [7:0] model_prev = 8'h00;

  task automatic step();
    @(negedge clk);
    ncount++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One poll: apply pad state, wait for the strobe, check masks, period and strobe width.
  task automatic run_poll(input string name, input logic [7:0] pad, input logic unpl,
                          input logic [7:0] exp_b, input logic [7:0] exp_p);
    int waited;
    pad_buttons = pad;
    unplugged   = unpl;
    waited      = 0;
    do begin
      step();
      waited++;
    end while (valid !== 1'b1 && waited < 150);
    check({name, "_valid"}, valid, 1);
    check({name, "_period"}, ncount - last_valid, POLL);
    check({name, "_buttons"}, buttons, exp_b);
    check({name, "_pressed"}, pressed, exp_p);
    last_valid = ncount;
    step();
    check({name, "_valid_drop"}, valid, 0);
    check({name, "_pressed_clr"}, pressed, 0);
    $display("poll %s pad=%02h unpl=%0d buttons=%02h pressed=%02h", name, pad, unpl, exp_b, exp_p);
  endtask

  initial begin
    int first_latch, latch_cnt, clk_rise, clk_hi, valid_at, valid_cnt, stray_pressed;
    logic prev_clk;
    logic [7:0] b_at_valid, p_at_valid;
    int waited;

    vecs[0] = '{8'h11, 1'b0, 8'h11, 8'h00};
    vecs[1] = '{(8'd1 << BTN_A) | (8'd1 << BTN_RIGHT), 1'b0, 8'h81, 8'h80};
    vecs[2] = '{8'h81, 1'b1, 8'h00, 8'h00};
    vecs[3] = '{8'h11, 1'b0, 8'h11, 8'h11};
    vecs[4] = '{8'hFF, 1'b0, 8'hFF, 8'hEE};
    vecs[5] = '{8'h00, 1'b0, 8'h00, 8'h00};

    // Reset state
    rst = 1'b1;
    pad_buttons = (8'd1 << BTN_A) | (8'd1 << BTN_UP);
    repeat (3) step();
    check("rst_latch", nes_latch, 0);
    check("rst_clk", nes_clk, 0);
    check("rst_buttons", buttons, 0);
    check("rst_pressed", pressed, 0);
    check("rst_valid", valid, 0);
    rst = 1'b0;
    ncount = 0;

    // First transaction: waveform shape and first-read pressed mask
    first_latch = -1; latch_cnt = 0; clk_rise = 0; clk_hi = 0;
    valid_at = -1; valid_cnt = 0; stray_pressed = 0; prev_clk = 1'b0;
    b_at_valid = 8'h00; p_at_valid = 8'h00;
    for (int i = 0; i < 140; i++) begin
      step();
      if (nes_latch === 1'b1) begin
        latch_cnt++;
        if (first_latch < 0) first_latch = ncount;
      end
      if (nes_clk === 1'b1) clk_hi++;
      if (nes_clk === 1'b1 && prev_clk !== 1'b1) clk_rise++;
      prev_clk = nes_clk;
      if (valid === 1'b1) begin
        valid_cnt++;
        valid_at   = ncount;
        b_at_valid = buttons;
        p_at_valid = pressed;
      end else if (pressed !== 8'h00) begin
        stray_pressed++;
      end
    end
    check("wave_latch_start", first_latch, POLL);
    check("wave_latch_len", latch_cnt, 2 * HALF);
    check("wave_clk_pulses", clk_rise, 7);
    check("wave_clk_high", clk_hi, 7 * HALF);
    check("wave_valid_delay", valid_at - (POLL - 1), 35);
    check("wave_valid_width", valid_cnt, 1);
    check("wave_stray_pressed", stray_pressed, 0);
    check("first_buttons", b_at_valid, 8'h11);
    check("first_pressed", p_at_valid, 8'h11);
    $display("poll first pad=11 buttons=%02h pressed=%02h at cycle %0d", b_at_valid, p_at_valid, valid_at);
    last_valid = valid_at;

    // Table vectors
    for (int v = 0; v < 6; v++) begin
      run_poll($sformatf("vec%0d", v), vecs[v].pad, vecs[v].unpl, vecs[v].exp_buttons,
               vecs[v].exp_pressed);
    end
    model_prev = vecs[5].exp_buttons;

    // Random polls against the mask model
    for (int r = 0; r < 10; r++) begin
      logic [7:0] rpad, eb, ep;
      logic       runpl;
      rpad  = 8'($urandom_range(0, 255));
      runpl = ($urandom_range(0, 7) == 0);
      eb    = runpl ? 8'h00 : rpad;
      ep    = eb & ~model_prev;
      model_prev = eb;
      run_poll($sformatf("rand%0d", r), rpad, runpl, eb, ep);
    end

    // Reset during the high phase of bit 3
    pad_buttons = 8'h5A;
    unplugged   = 1'b0;
    waited = 0;
    while (nes_latch !== 1'b1 && waited < 150) begin step(); waited++; end
    check("midrst_latch_seen", nes_latch, 1);
    clk_rise = 0; prev_clk = nes_clk; waited = 0;
    while (clk_rise < 4 && waited < 60) begin
      step();
      waited++;
      if (nes_clk === 1'b1 && prev_clk !== 1'b1) clk_rise++;
      prev_clk = nes_clk;
    end
    check("midrst_bit3_high", clk_rise, 4);
    rst = 1'b1;
    step();
    check("midrst_latch", nes_latch, 0);
    check("midrst_clk", nes_clk, 0);
    check("midrst_buttons", buttons, 0);
    check("midrst_valid", valid, 0);
    rst = 1'b0;
    ncount = 0;
    valid_at = -1; valid_cnt = 0;
    b_at_valid = 8'h00; p_at_valid = 8'h00;
    for (int i = 0; i < 140; i++) begin
      step();
      if (valid === 1'b1) begin
        valid_cnt++;
        if (valid_at < 0) valid_at = ncount;
        b_at_valid = buttons;
        p_at_valid = pressed;
      end
    end
    check("midrst_valid_at", valid_at, POLL + 17 * HALF);
    check("midrst_valid_cnt", valid_cnt, 1);
    check("midrst_buttons_after", b_at_valid, 8'h5A);
    check("midrst_pressed_after", p_at_valid, 8'h5A);
    $display("poll after_reset pad=5a buttons=%02h pressed=%02h at cycle %0d", b_at_valid, p_at_valid, valid_at);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
